// File: rtl/uart_rx_poller.sv
// Polls the UART receive status over Avalon-MM and buffers good bytes in a
// first-word-fall-through FIFO with overflow and framing-error statistics.
module uart_rx_poller #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_irq,
  input  logic          uart_err,
  output logic          avm_read,
  input  logic [7:0]    avm_readdata,
  input  logic          avm_waitrequest,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  output logic [7:0]    err_cnt,
  input  logic          clr
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t          state_q;
  state_t          state_d;
  logic            accept;
  logic            good;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_next;
  logic [LW-1:0]   level_next;
  logic [7:0]      head_next;
  logic [7:0]      mem [DEPTH];

  // Poll state register; avm_read is registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      avm_read <= 1'b0;
    end else begin
      state_q  <= state_d;
      avm_read <= (state_d == READ);
    end
  end

  // HOLD gives the UART one cycle to drop irq before it is sampled again
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (uart_irq) state_d = READ;
      READ:    if (!avm_waitrequest) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, push/pop and next-head computation
  always_comb begin
    accept      = (state_q == READ) && !avm_waitrequest;
    good        = accept && !uart_err;
    full        = (fifo_level == LW'(DEPTH));
    pop         = rx_valid && rx_ready;
    push        = good && (!full || pop);
    drop        = good && full && !pop;
    rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_next  = fifo_level + LW'(push) - LW'(pop);
    // A byte written this edge into the slot that becomes the head bypasses memory
    head_next   = (push && (wr_ptr == rd_ptr_next)) ? avm_readdata : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  // FIFO pointers and registered head/level outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_next;
      fifo_level <= level_next;
      rx_valid   <= (level_next != '0);
      rx_data    <= head_next;
    end
  end

  // Statistics; clr takes priority over same-cycle events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (clr) begin
      overflow <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (accept && uart_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
